// File: rtl/if_fetch_unit_pkg.sv
// Shared state encodings and default constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IF_STATE_BOOT    = 2'd0,
        IF_STATE_FETCH   = 2'd1,
        IF_STATE_DISCARD = 2'd2,
        IF_STATE_HOLD    = 2'd3
    } if_state_e;

    localparam logic [31:0] IF_DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          IF_DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory bus, IF/ID packet and hazard-controller handshake.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_stall;
    logic              IF_flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_pc;
    logic [DATA_W-1:0] fetch_instr;
    logic              InstrReq;
    logic              InstrWait;

    modport master (
        input  IF_stall, IF_flush, redirect_pc, im_rvalid, im_rdata,
        output im_req, im_addr, fetch_valid, fetch_pc, fetch_instr, InstrReq, InstrWait
    );

    modport slave (
        output IF_stall, IF_flush, redirect_pc, im_rvalid, im_rdata,
        input  im_req, im_addr, fetch_valid, fetch_pc, fetch_instr, InstrReq, InstrWait
    );
endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry {pc, instr} buffer that parks a returned instruction while ID is stalled.
module if_hold_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic              valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload is only meaningful while valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            pc_out    <= pc_in;
            instr_out <= instr_in;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory request in flight,
// and hands {pc, instr} packets to IF/ID under hazard-controller stall/flush.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = IF_DEFAULT_RESET_PC,
    parameter int              PC_STEP  = IF_DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_unit_if.master bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              im_req_c;
    logic              fetch_valid_c;
    logic              buf_load, buf_clear;
    logic              hold_valid;
    logic [ADDR_W-1:0] buf_pc;
    logic [DATA_W-1:0] buf_instr;

    if_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .pc_in     (req_addr_q),
        .instr_in  (bus.im_rdata),
        .valid     (hold_valid),
        .pc_out    (buf_pc),
        .instr_out (buf_instr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IF_STATE_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        im_req_c      = 1'b0;
        fetch_valid_c = 1'b0;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;

        unique case (state_q)
            IF_STATE_BOOT: begin
                state_d    = IF_STATE_FETCH;
                req_addr_d = pc_q;
            end

            IF_STATE_FETCH: begin
                im_req_c = 1'b1;
                if (bus.im_rvalid) begin
                    if (bus.IF_flush) begin
                        pc_d       = bus.redirect_pc;
                        req_addr_d = bus.redirect_pc;
                    end else if (!bus.IF_stall) begin
                        fetch_valid_c = 1'b1;
                        pc_d          = req_addr_q + STEP;
                        req_addr_d    = req_addr_q + STEP;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = IF_STATE_HOLD;
                    end
                end else if (bus.IF_flush) begin
                    // The bus request cannot be withdrawn; drain it before redirecting.
                    pc_d    = bus.redirect_pc;
                    state_d = IF_STATE_DISCARD;
                end
            end

            IF_STATE_DISCARD: begin
                im_req_c = 1'b1;
                if (bus.IF_flush) begin
                    pc_d = bus.redirect_pc;
                end
                if (bus.im_rvalid) begin
                    req_addr_d = bus.IF_flush ? bus.redirect_pc : pc_q;
                    state_d    = IF_STATE_FETCH;
                end
            end

            IF_STATE_HOLD: begin
                fetch_valid_c = hold_valid && !bus.IF_flush;
                if (bus.IF_flush) begin
                    buf_clear  = 1'b1;
                    pc_d       = bus.redirect_pc;
                    req_addr_d = bus.redirect_pc;
                    state_d    = IF_STATE_FETCH;
                end else if (!bus.IF_stall) begin
                    buf_clear  = 1'b1;
                    pc_d       = buf_pc + STEP;
                    req_addr_d = buf_pc + STEP;
                    state_d    = IF_STATE_FETCH;
                end
            end

            default: begin
                state_d = IF_STATE_BOOT;
            end
        endcase
    end

    assign bus.im_req      = im_req_c;
    assign bus.im_addr     = req_addr_q;
    assign bus.InstrReq    = im_req_c;
    assign bus.InstrWait   = im_req_c && !bus.im_rvalid;
    assign bus.fetch_valid = fetch_valid_c;
    assign bus.fetch_pc    = (state_q == IF_STATE_HOLD) ? buf_pc : req_addr_q;
    assign bus.fetch_instr = !fetch_valid_c              ? '0
                           : (state_q == IF_STATE_HOLD)  ? buf_instr
                           :                               bus.im_rdata;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with hand-written reset sequences.
module tb_if_fetch_unit;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] rdx;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        iwait;
        logic        fv;
        logic [31:0] fpc;
        logic [31:0] fi;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    if_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic stall, logic flush, logic [31:0] rdx, logic rvalid,
                                logic [31:0] rdata, logic req, logic [31:0] addr, logic iwait,
                                logic fv, logic [31:0] fpc, logic [31:0] fi);
        vec_t v;
        v.stall = stall; v.flush = flush; v.rdx = rdx; v.rvalid = rvalid; v.rdata = rdata;
        v.req = req; v.addr = addr; v.iwait = iwait; v.fv = fv; v.fpc = fpc; v.fi = fi;
        return v;
    endfunction

    // Zero-wait fetch that is delivered straight through.
    function automatic vec_t zw(logic [31:0] pc);
        return mk(0, 0, 0, 1, 32'hA000_0000 | pc, 1, pc, 0, 1, pc, 32'hA000_0000 | pc);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic stall, logic flush, logic [31:0] rdx, logic rvalid, logic [31:0] rdata);
        bus.IF_stall    = stall;
        bus.IF_flush    = flush;
        bus.redirect_pc = rdx;
        bus.im_rvalid   = rvalid;
        bus.im_rdata    = rdata;
    endtask

    task automatic check_outputs(string tag, vec_t v);
        chk({tag, " im_req"},      32'(bus.im_req),      32'(v.req));
        chk({tag, " im_addr"},     bus.im_addr,          v.addr);
        chk({tag, " InstrReq"},    32'(bus.InstrReq),    32'(v.req));
        chk({tag, " InstrWait"},   32'(bus.InstrWait),   32'(v.iwait));
        chk({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(v.fv));
        chk({tag, " fetch_pc"},    bus.fetch_pc,         v.fpc);
        chk({tag, " fetch_instr"}, bus.fetch_instr,      v.fi);
    endtask

    initial begin
        vec_t rst_v;
        vec_t v;
        rst_v = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);

        // Boot, then 0-wait sequential fetches
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(zw(32'h0));
        vecs.push_back(zw(32'h4));
        vecs.push_back(zw(32'h8));
        vecs.push_back(zw(32'hC));
        // Two wait states at 0x10
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 32'h10, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 32'h10, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0010, 1, 32'h10, 0, 1, 32'h10, 32'hB000_0010));
        for (int a = 32'h14; a <= 32'h1C; a += 4) vecs.push_back(zw(32'(a)));
        // Stall when 0x20 returns: held three cycles, then consumed
        vecs.push_back(mk(1, 0, 0, 1, 32'hC000_0020, 1, 32'h20, 0, 0, 32'h20, 32'h0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h20, 0, 1, 32'h20, 32'hC000_0020));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h20, 0, 1, 32'h20, 32'hC000_0020));
        for (int a = 32'h24; a <= 32'h2C; a += 4) vecs.push_back(zw(32'(a)));
        // Flush during wait at 0x30: request drains, data dropped
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 1, 32'h30, 1, 0, 32'h30, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h30, 1, 0, 32'h30, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_0030, 1, 32'h30, 0, 0, 32'h30, 32'h0));
        // Flush coincident with rvalid at 0x100
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'hDEAD_0100, 1, 32'h100, 0, 0, 32'h100, 32'h0));
        // Repeated flushes while draining: last redirect wins
        vecs.push_back(mk(0, 1, 32'h2F0, 0, 0, 1, 32'h200, 1, 0, 32'h200, 32'h0));
        vecs.push_back(mk(0, 1, 32'h300, 0, 0, 1, 32'h200, 1, 0, 32'h200, 32'h0));
        vecs.push_back(mk(0, 1, 32'h400, 0, 0, 1, 32'h200, 1, 0, 32'h200, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_0200, 1, 32'h200, 0, 0, 32'h200, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hD000_0400, 1, 32'h400, 0, 1, 32'h400, 32'hD000_0400));
        // Redirect to the top of the address space, then wrap
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h404, 1, 0, 32'h404, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_0404, 1, 32'h404, 0, 0, 32'h404, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hE000_FFFC, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'hE000_FFFC));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 32'h0, 32'h0));
        // Flush out of HOLD suppresses the buffered packet
        vecs.push_back(mk(1, 0, 0, 1, 32'hF000_0000, 1, 32'h0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h500, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
        // Enter DISCARD at 0x500 for the reset sequence below
        vecs.push_back(mk(0, 1, 32'h600, 0, 0, 1, 32'h500, 1, 0, 32'h500, 32'h0));

        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            check_outputs($sformatf("reset c%0d", c), rst_v);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = 1'b0;
            drive(vecs[i].stall, vecs[i].flush, vecs[i].rdx, vecs[i].rvalid, vecs[i].rdata);
            #2;
            check_outputs($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset while DISCARD is waiting; late rvalid must be ignored
        @(negedge clk);
        drive(0, 0, 0, 1, 32'hBAD0_0500);
        rst = 1'b1;
        #2;
        check_outputs("rst in DISCARD", rst_v);
        @(negedge clk);
        #2;
        check_outputs("rst held", rst_v);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_outputs("boot ignores rvalid", rst_v);
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h1234_5678);
        #2;
        v = mk(0, 0, 0, 1, 32'h1234_5678, 1, 32'h0, 0, 1, 32'h0, 32'h1234_5678);
        check_outputs("refetch 0x0", v);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #2;
        v = mk(0, 0, 0, 0, 0, 1, 32'h4, 1, 0, 32'h4, 32'h0);
        check_outputs("refetch 0x4 wait", v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
